// File: rtl/ins_encoder_r32i.sv
// RV32I instruction encoder: packs field bundles into instruction words
// and streams them out with an auto-incrementing RAM byte address.
module ins_encoder_r32i #(
    parameter int dataW     = 32,
    parameter int ADDR_W    = 12,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              nReset,
    input  logic              restart,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        ins_class,
    input  logic [4:0]        rd,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [2:0]        funct3,
    input  logic              alt,
    input  logic [dataW-1:0]  imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [dataW-1:0]  out_word,
    output logic [ADDR_W-1:0] out_addr,
    output logic              err_valid,
    output logic [1:0]        err_code,
    output logic              wrapped
);

    typedef struct packed {
        logic [3:0]       insClass;
        logic [4:0]       rd;
        logic [4:0]       rs1;
        logic [4:0]       rs2;
        logic [2:0]       funct3;
        logic             alt;
        logic [dataW-1:0] imm;
    } fields_t;

    localparam logic [ADDR_W-1:0] baseAddr = ADDR_W'(BASE_ADDR);

    localparam logic [3:0] clOppi   = 4'd0;
    localparam logic [3:0] clOppr   = 4'd1;
    localparam logic [3:0] clLui    = 4'd2;
    localparam logic [3:0] clAuipc  = 4'd3;
    localparam logic [3:0] clJal    = 4'd4;
    localparam logic [3:0] clJalr   = 4'd5;
    localparam logic [3:0] clBranch = 4'd6;
    localparam logic [3:0] clLoad   = 4'd7;
    localparam logic [3:0] clStore  = 4'd8;

    localparam logic [6:0] opOppi   = 7'b0010011;
    localparam logic [6:0] opOppr   = 7'b0110011;
    localparam logic [6:0] opLui    = 7'b0110111;
    localparam logic [6:0] opAuipc  = 7'b0010111;
    localparam logic [6:0] opJal    = 7'b1101111;
    localparam logic [6:0] opJalr   = 7'b1100111;
    localparam logic [6:0] opBranch = 7'b1100011;
    localparam logic [6:0] opLoad   = 7'b0000011;
    localparam logic [6:0] opStore  = 7'b0100011;

    localparam logic [1:0] errClass = 2'd0;
    localparam logic [1:0] errRange = 2'd1;
    localparam logic [1:0] errAlign = 2'd2;
    localparam logic [1:0] errULow  = 2'd3;

    fields_t          s1Q;
    logic             s1Valid;
    logic             s1Adv;
    logic             accept;
    logic             xfer;
    logic [dataW-1:0] encWord;
    logic             encBad;
    logic [1:0]       encCode;
    logic             iFits;
    logic             bFits;
    logic             jFits;
    logic             shFits;

    assign s1Adv    = !out_valid || out_ready;
    assign in_ready = nReset && (!s1Valid || s1Adv);
    assign accept   = in_valid && in_ready;
    assign xfer     = out_valid && out_ready;

    // Signed-range fits: all bits above the field's sign bit must match it.
    assign iFits  = (&s1Q.imm[dataW-1:11]) || !(|s1Q.imm[dataW-1:11]);
    assign bFits  = (&s1Q.imm[dataW-1:12]) || !(|s1Q.imm[dataW-1:12]);
    assign jFits  = (&s1Q.imm[dataW-1:20]) || !(|s1Q.imm[dataW-1:20]);
    assign shFits = !(|s1Q.imm[dataW-1:5]);

    // Stage 1: capture the field bundle on handshake, drain when S2 takes it.
    always_ff @(posedge clk) begin
        if (!nReset) begin
            s1Valid <= 1'b0;
        end else if (restart) begin
            s1Valid <= 1'b0;
        end else if (accept) begin
            s1Valid <= 1'b1;
            s1Q     <= '{insClass: ins_class, rd: rd, rs1: rs1, rs2: rs2,
                         funct3: funct3, alt: alt, imm: imm};
        end else if (s1Adv) begin
            s1Valid <= 1'b0;
        end
    end

    // Encode the S1 bundle and classify it; U beats alignment beats range.
    always_comb begin
        encWord = '0;
        encBad  = 1'b0;
        encCode = errClass;
        unique case (s1Q.insClass)
            clOppi: begin
                if (s1Q.funct3[1:0] == 2'b01) begin
                    encWord = {1'b0, s1Q.alt & s1Q.funct3[2], 5'b0,
                               s1Q.imm[4:0], s1Q.rs1, s1Q.funct3,
                               s1Q.rd, opOppi};
                    if (!shFits) {encBad, encCode} = {1'b1, errRange};
                end else begin
                    encWord = {s1Q.imm[11:0], s1Q.rs1, s1Q.funct3,
                               s1Q.rd, opOppi};
                    if (!iFits) {encBad, encCode} = {1'b1, errRange};
                end
            end
            clOppr: begin
                encWord = {1'b0, s1Q.alt, 5'b0, s1Q.rs2, s1Q.rs1,
                           s1Q.funct3, s1Q.rd, opOppr};
            end
            clLui: begin
                encWord = {s1Q.imm[31:12], s1Q.rd, opLui};
                if (|s1Q.imm[11:0]) {encBad, encCode} = {1'b1, errULow};
            end
            clAuipc: begin
                encWord = {s1Q.imm[31:12], s1Q.rd, opAuipc};
                if (|s1Q.imm[11:0]) {encBad, encCode} = {1'b1, errULow};
            end
            clJal: begin
                encWord = {s1Q.imm[20], s1Q.imm[10:1], s1Q.imm[11],
                           s1Q.imm[19:12], s1Q.rd, opJal};
                if (s1Q.imm[0]) {encBad, encCode} = {1'b1, errAlign};
                else if (!jFits) {encBad, encCode} = {1'b1, errRange};
            end
            clJalr: begin
                encWord = {s1Q.imm[11:0], s1Q.rs1, 3'b000, s1Q.rd, opJalr};
                if (!iFits) {encBad, encCode} = {1'b1, errRange};
            end
            clBranch: begin
                encWord = {s1Q.imm[12], s1Q.imm[10:5], s1Q.rs2, s1Q.rs1,
                           s1Q.funct3, s1Q.imm[4:1], s1Q.imm[11], opBranch};
                if (s1Q.imm[0]) {encBad, encCode} = {1'b1, errAlign};
                else if (!bFits) {encBad, encCode} = {1'b1, errRange};
            end
            clLoad: begin
                encWord = {s1Q.imm[11:0], s1Q.rs1, s1Q.funct3,
                           s1Q.rd, opLoad};
                if (!iFits) {encBad, encCode} = {1'b1, errRange};
            end
            clStore: begin
                encWord = {s1Q.imm[11:5], s1Q.rs2, s1Q.rs1, s1Q.funct3,
                           s1Q.imm[4:0], opStore};
                if (!iFits) {encBad, encCode} = {1'b1, errRange};
            end
            default: begin
                encBad  = 1'b1;
                encCode = errClass;
            end
        endcase
    end

    // Stage 2: register good words for output, pulse the error flag for bad ones.
    always_ff @(posedge clk) begin
        if (!nReset) begin
            out_valid <= 1'b0;
            out_word  <= '0;
            err_valid <= 1'b0;
            err_code  <= errClass;
        end else if (restart) begin
            out_valid <= 1'b0;
            err_valid <= 1'b0;
        end else begin
            err_valid <= 1'b0;
            if (s1Adv) begin
                out_valid <= s1Valid && !encBad;
                if (s1Valid && !encBad) out_word <= encWord;
                if (s1Valid && encBad) begin
                    err_valid <= 1'b1;
                    err_code  <= encCode;
                end
            end
        end
    end

    // Write address: advance on each accepted word, flag the first wrap.
    always_ff @(posedge clk) begin
        if (!nReset || restart) begin
            out_addr <= baseAddr;
            wrapped  <= 1'b0;
        end else if (xfer) begin
            out_addr <= out_addr + ADDR_W'(4);
            if (&out_addr[ADDR_W-1:2]) wrapped <= 1'b1;
        end
    end

endmodule
